vga_scan_driver: RTL and testbench
==================================

# vga_scan_driver

Generates VGA raster timing and composites pixel layers into the final video output. It drives the `hcounter`/`vcounter` bus consumed by the glyph and sprite renderers such as the score-digit blocks. It collects each renderer's `visible`/`rgb` pair back, resolves priority, and emits registered sync, data-enable and 24-bit colour to the display pins. It is the producer and consumer end of the renderer pixel interface.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch, in pixels
- `H_SYNC`, 96, horizontal sync width, in pixels
- `H_BP`, 48, horizontal back porch, in pixels
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch, in lines
- `V_SYNC`, 2, vertical sync width, in lines
- `V_BP`, 33, vertical back porch, in lines
- `LAYERS`, 4, number of renderer layers; must be 1..16
- `BG_COLOR`, 24'h000000, colour of active pixels not covered by any layer
- `BORDER_COLOR`, 24'hffffff, border colour (used only when `VGA_BORDER_EN` is defined)

Ports (reset is asynchronous and active-high):
- `clk` in 1: system clock
- `rst` in 1: asynchronous active-high reset
- `pix_en` in 1: pixel-rate clock enable; the block advances only on cycles where it is high
- `hcounter` out 10: current horizontal position, 0..H_TOTAL-1
- `vcounter` out 10: current vertical position, 0..V_TOTAL-1
- `layer_visible` in LAYERS: per-layer coverage of the current (`hcounter`, `vcounter`) position; combinational from the renderers
- `layer_rgb` in 24*LAYERS: per-layer colour; layer i occupies bits [24i+23:24i]
- `vga_hs` out 1: horizontal sync, active low
- `vga_vs` out 1: vertical sync, active low
- `vga_de` out 1: data enable, high in the active area
- `vga_rgb` out 24: output pixel colour
- `frame_start` out 1: one-clock pulse when the counters wrap to (0,0)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 with defaults); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 with defaults).
- Both totals must be ≤ 1024. An elaboration-time check fails the build if either exceeds 1024.
- Counter update on `pix_en`:
  - `hcounter` increments.
  - At H_TOTAL-1, `hcounter` wraps to 0 and `vcounter` increments.
  - At V_TOTAL-1 with `hcounter` = H_TOTAL-1, `vcounter` wraps to 0.
- Active area: `hcounter` < H_ACTIVE and `vcounter` < V_ACTIVE.
- Horizontal sync window: H_ACTIVE+H_FP ≤ `hcounter` < H_ACTIVE+H_FP+H_SYNC.
- Vertical sync window: V_ACTIVE+V_FP ≤ `vcounter` < V_ACTIVE+V_FP+V_SYNC.
- Compositor, evaluated from the current counters:
  - Outside the active area: output 0.
  - Otherwise: `layer_rgb` of the lowest-indexed layer with `layer_visible` set.
  - If no layer is set: BG_COLOR.
- Any `layer_visible` bit outside the active area is ignored.

## Timing
- Reset values: `hcounter` 0, `vcounter` 0, `vga_hs` 1, `vga_vs` 1, `vga_de` 0, `vga_rgb` 0, `frame_start` 0.
- Reset acts immediately, without waiting for a clock edge. Reset mid-frame discards the frame; the first enabled cycle after release starts from (0,0).
- On each `pix_en` cycle, `vga_hs`, `vga_vs`, `vga_de` and `vga_rgb` are registered from the pre-increment counter values. All outputs are mutually aligned, with one pixel of latency relative to `hcounter`/`vcounter`.
- When `pix_en` is low, all registers hold.
- `frame_start` is high for exactly one `clk` cycle: the `pix_en` cycle on which the counters go from (H_TOTAL-1, V_TOTAL-1) to (0,0). It is low on all other cycles, including when `pix_en` is low.
- Renderers must settle combinationally within one `clk` period of a counter change.

## Configuration
- `VGA_BORDER_EN` defined: active pixels with `hcounter` ∈ {0, H_ACTIVE-1} or `vcounter` ∈ {0, V_ACTIVE-1} output BORDER_COLOR. The border takes priority over all layers.
- `VGA_BORDER_EN` undefined: no border logic is built; the compositor behaves exactly as described in Operation.

## Test plan
- Reset release with `pix_en`=1, no layers set:
  - After the first edge: `hcounter`=1, `vga_de`=1, `vga_rgb`=000000.
  - Assert `rst` mid-line at `hcounter`=300: all outputs return to reset values before the next clock edge.
- Horizontal sync: `hcounter`=656 presented → `vga_hs`=0 on the next cycle. `vga_hs` stays low for exactly 96 pixel ticks, then returns to 1. `vga_de` falls after `hcounter`=639.
- Line and frame wrap:
  - 799→0 increments `vcounter`.
  - (799,524)→(0,0) raises `frame_start` for one cycle.
  - `vga_vs`=0 exactly for `vcounter` 490..491, delayed by one pixel.
- Priority with LAYERS=4:
  - `layer_visible`=4'b0110, layer1=ff0000, layer2=00ff00 → `vga_rgb`=ff0000.
  - `layer_visible`=0 → BG_COLOR.
  - `layer_visible`=4'b1111 while `hcounter`=700 → 000000.
- `pix_en` high every other cycle: counters advance only on enabled cycles. `frame_start` period = 2×800×525 = 840000 clocks.
- `VGA_BORDER_EN` defined, layer0 visible everywhere with colour 0000ff: pixel (0,5) and (639,5) → ffffff; pixel (1,5) → 0000ff.

Source files
------------

// File: rtl/vga_scan_driver.sv
// vga_scan_driver
// Generates VGA raster timing (hcounter/vcounter) for the renderers and
// composites the returned per-layer coverage/colour into registered sync,
// data-enable and 24-bit colour outputs.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   pix_en          pixel-rate clock enable
//   hcounter        current horizontal position (0..H_TOTAL-1)
//   vcounter        current vertical position   (0..V_TOTAL-1)
//   layer_visible   per-layer coverage of the current position
//   layer_rgb       per-layer colour, layer i in [24i+23:24i]
//   vga_hs, vga_vs  active-low syncs (registered, one pixel behind counters)
//   vga_de          data enable (registered)
//   vga_rgb         output colour (registered)
//   frame_start     one-clock pulse on the wrap to (0,0)
//
// Optional feature macro: VGA_BORDER_EN (draws a BORDER_COLOR frame around
// the active area, taking priority over every layer).

module vga_scan_driver #(
    parameter int          H_ACTIVE     = 640,
    parameter int          H_FP         = 16,
    parameter int          H_SYNC       = 96,
    parameter int          H_BP         = 48,
    parameter int          V_ACTIVE     = 480,
    parameter int          V_FP         = 10,
    parameter int          V_SYNC       = 2,
    parameter int          V_BP         = 33,
    parameter int          LAYERS       = 4,
    parameter logic [23:0] BG_COLOR     = 24'h000000,
    parameter logic [23:0] BORDER_COLOR = 24'hffffff
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pix_en,
    output logic [9:0]           hcounter,
    output logic [9:0]           vcounter,
    input  logic [LAYERS-1:0]    layer_visible,
    input  logic [24*LAYERS-1:0] layer_rgb,
    output logic                 vga_hs,
    output logic                 vga_vs,
    output logic                 vga_de,
    output logic [23:0]          vga_rgb,
    output logic                 frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEGIN = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEGIN = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    generate
        if (H_TOTAL > 1024) begin : g_h_total_check
            $error("vga_scan_driver: H_TOTAL exceeds 1024");
        end
        if (V_TOTAL > 1024) begin : g_v_total_check
            $error("vga_scan_driver: V_TOTAL exceeds 1024");
        end
        if (LAYERS < 1 || LAYERS > 16) begin : g_layers_check
            $error("vga_scan_driver: LAYERS must be 1..16");
        end
    endgenerate

    logic [9:0]  hcount_q, hcount_d;
    logic [9:0]  vcount_q, vcount_d;
    logic        hs_q, vs_q, de_q, fs_q;
    logic        hs_d, vs_d, de_d, fs_d;
    logic [23:0] rgb_q, rgb_d;
    logic        h_end, v_end, active;

    assign h_end  = (hcount_q == H_LAST);
    assign v_end  = (vcount_q == V_LAST);
    assign active = (hcount_q < H_ACT) && (vcount_q < V_ACT);

    always_comb begin
        hcount_d = hcount_q + 10'd1;
        vcount_d = vcount_q;
        if (h_end) begin
            hcount_d = 10'd0;
            vcount_d = v_end ? 10'd0 : vcount_q + 10'd1;
        end
    end

    always_comb begin
        hs_d = !((hcount_q >= HS_BEGIN) && (hcount_q < HS_END));
        vs_d = !((vcount_q >= VS_BEGIN) && (vcount_q < VS_END));
        de_d = active;
        fs_d = pix_en && h_end && v_end;
    end

    // Walk from the highest layer down so the lowest-indexed visible layer
    // is the last assignment and therefore wins.
    always_comb begin
        rgb_d = BG_COLOR;
        for (int i = LAYERS - 1; i >= 0; i--) begin
            if (layer_visible[i]) begin
                rgb_d = layer_rgb[24*i +: 24];
            end
        end
`ifdef VGA_BORDER_EN
        if (hcount_q == 10'd0 || hcount_q == H_ACT - 10'd1 ||
            vcount_q == 10'd0 || vcount_q == V_ACT - 10'd1) begin
            rgb_d = BORDER_COLOR;
        end
`endif
        if (!active) begin
            rgb_d = 24'h000000;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount_q <= 10'd0;
            vcount_q <= 10'd0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            de_q     <= 1'b0;
            rgb_q    <= 24'h000000;
            fs_q     <= 1'b0;
        end else begin
            // frame_start is rewritten every clock so it never stretches
            // across cycles where pix_en is low.
            fs_q <= fs_d;
            if (pix_en) begin
                hcount_q <= hcount_d;
                vcount_q <= vcount_d;
                hs_q     <= hs_d;
                vs_q     <= vs_d;
                de_q     <= de_d;
                rgb_q    <= rgb_d;
            end
        end
    end

    assign hcounter    = hcount_q;
    assign vcounter    = vcount_q;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_de      = de_q;
    assign vga_rgb     = rgb_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_scan_driver.sv
// Directed bench for vga_scan_driver using a shrunken raster so whole
// frames fit in a short run:
//   H: active 16, fp 4, sync 6, bp 4  -> H_TOTAL 30, hsync at h 20..25
//   V: active 10, fp 2, sync 2, bp 3  -> V_TOTAL 17, vsync at v 12..13

module tb_vga_scan_driver;

    localparam int          LAYERS = 4;
    localparam logic [23:0] BG     = 24'h123456;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 pix_en;
    logic [9:0]           hcounter, vcounter;
    logic [LAYERS-1:0]    layer_visible;
    logic [24*LAYERS-1:0] layer_rgb;
    logic                 vga_hs, vga_vs, vga_de, frame_start;
    logic [23:0]          vga_rgb;

    int total = 0;
    int bad   = 0;

    vga_scan_driver #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .LAYERS(LAYERS), .BG_COLOR(BG), .BORDER_COLOR(24'hffffff)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .hcounter(hcounter), .vcounter(vcounter),
        .layer_visible(layer_visible), .layer_rgb(layer_rgb),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
        .vga_rgb(vga_rgb), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int h, input int v);
        int n = 0;
        while (!(hcounter == 10'(h) && vcounter == 10'(v)) && n < 2000) begin
            tick();
            n++;
        end
        check("run_to reached", {31'd0, n < 2000}, 32'd1);
    endtask

    initial begin
        int lows, pulses, first_fs, second_fs;
        logic [9:0] h_hold;

        rst = 1'b1;
        pix_en = 1'b1;
        layer_visible = '0;
        layer_rgb = '0;

        #23;
        check("reset hcounter", hcounter, 0);
        check("reset vcounter", vcounter, 0);
        check("reset hs", vga_hs, 1);
        check("reset vs", vga_vs, 1);
        check("reset de", vga_de, 0);
        check("reset rgb", vga_rgb, 0);
        check("reset fs", frame_start, 0);
        rst = 1'b0;

        tick();
        check("first edge hcounter", hcounter, 1);
        check("first edge de", vga_de, 1);
        check("first edge rgb bg", vga_rgb, 32'h123456);

        layer_rgb[24*1 +: 24] = 24'hff0000;
        layer_rgb[24*2 +: 24] = 24'h00ff00;
        layer_rgb[24*0 +: 24] = 24'h0000ff;
        layer_rgb[24*3 +: 24] = 24'habcdef;
        layer_visible = 4'b0110;
        tick();
        check("prio 0110", vga_rgb, 32'hff0000);
        layer_visible = 4'b0000;
        tick();
        check("prio none", vga_rgb, 32'h123456);
        layer_visible = 4'b1111;
        tick();
        check("prio 1111", vga_rgb, 32'h0000ff);
        layer_visible = 4'b1000;
        tick();
        check("prio 1000", vga_rgb, 32'habcdef);

        layer_visible = 4'b1111;
        run_to(20, 0);
        tick();
        check("blank rgb", vga_rgb, 0);
        check("blank de", vga_de, 0);
        layer_visible = 4'b0000;

        run_to(15, 1);
        tick();
        check("de last active", vga_de, 1);
        tick();
        check("de falls", vga_de, 0);

        run_to(19, 1);
        tick();
        check("hs before window", vga_hs, 1);
        tick();
        check("hs window start", vga_hs, 0);
        run_to(25, 1);
        tick();
        check("hs window end", vga_hs, 0);
        tick();
        check("hs released", vga_hs, 1);

        run_to(0, 2);
        lows = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (!vga_hs) lows++;
        end
        check("hs low count", lows, 6);

        run_to(29, 2);
        tick();
        check("line wrap h", hcounter, 0);
        check("line wrap v", vcounter, 3);

        run_to(29, 11);
        tick();
        check("vs before window", vga_vs, 1);
        tick();
        check("vs window start", vga_vs, 0);
        run_to(29, 13);
        tick();
        check("vs window end", vga_vs, 0);
        tick();
        check("vs released", vga_vs, 1);

        run_to(29, 16);
        check("fs before wrap", frame_start, 0);
        tick();
        check("frame wrap h", hcounter, 0);
        check("frame wrap v", vcounter, 0);
        check("fs pulse", frame_start, 1);
        tick();
        check("fs one cycle", frame_start, 0);

        run_to(0, 0);
        lows = 0;
        pulses = 0;
        for (int i = 0; i < 510; i++) begin
            tick();
            if (!vga_vs) lows++;
            if (frame_start) pulses++;
        end
        check("vs low count", lows, 60);
        check("fs per frame", pulses, 1);

        h_hold = hcounter;
        pix_en = 1'b0;
        tick();
        check("hold hcounter", hcounter, 32'(h_hold));
        check("hold fs low", frame_start, 0);
        tick();
        check("hold hcounter 2", hcounter, 32'(h_hold));

        first_fs = -1;
        second_fs = -1;
        for (int c = 0; c < 3000 && second_fs < 0; c++) begin
            pix_en = c[0];
            tick();
            if (frame_start) begin
                if (first_fs < 0) first_fs = c;
                else second_fs = c;
            end
        end
        check("fs period half rate", second_fs - first_fs, 1020);

        pix_en = 1'b1;
        run_to(10, 3);
        #1 rst = 1'b1;
        #1;
        check("midreset hcounter", hcounter, 0);
        check("midreset vcounter", vcounter, 0);
        check("midreset de", vga_de, 0);
        check("midreset rgb", vga_rgb, 0);
        check("midreset hs", vga_hs, 1);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("after reset hcounter", hcounter, 1);
        check("after reset vcounter", vcounter, 0);

`ifdef VGA_BORDER_EN
        layer_rgb[24*0 +: 24] = 24'h0000ff;
        layer_visible = 4'b0001;
        run_to(0, 5);
        tick();
        check("border left", vga_rgb, 32'hffffff);
        tick();
        check("border inner", vga_rgb, 32'h0000ff);
        run_to(15, 5);
        tick();
        check("border right", vga_rgb, 32'hffffff);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
